// File: rtl/fft_input_loader.sv
// fft_input_loader: moves N=2^log2n FIFO samples into FFT RAM at bit-reversed addresses
module fft_input_loader #(
  parameter int MAX_LOG2N = 10,
  parameter int MIN_LOG2N = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = MAX_LOG2N
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [3:0]        i_log2n,
  input  logic              i_fifo_empty,
  output logic              o_store_valid,
  input  logic [DATA_W-1:0] i_store_data,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam logic [3:0] MIN_N = 4'(MIN_LOG2N);
  localparam logic [3:0] MAX_N = 4'(MAX_LOG2N);
  localparam logic [3:0] AW_N = 4'(ADDR_W);
  state_t state, next_state;
  logic [3:0] n_reg;
  logic [ADDR_W:0] rd_cnt;
  logic [ADDR_W:0] n_full;
  logic [ADDR_W-1:0] rev_full;
  logic [ADDR_W-1:0] addr_q;
  logic start_ok;
  logic last_rd;
  logic rd_d;
  logic err_q;
  assign n_full = (ADDR_W+1)'(1) << n_reg;
  assign start_ok = i_start && (i_log2n >= MIN_N) && (i_log2n <= MAX_N);
  assign last_rd = o_store_valid && (rd_cnt == n_full - 1'b1);
  // full-width reversal; shifting right by ADDR_W-n_reg leaves an n_reg-bit reversal with zero upper bits
  always_comb begin
    rev_full = '0;
    for (int k = 0; k < ADDR_W; k++) rev_full[ADDR_W-1-k] = rd_cnt[k];
  end
  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= next_state;
  end
  // next-state: start only from IDLE, last read ends LOAD, DRAIN and DONE last one cycle each
  always_comb begin
    next_state = state;
    if (state == IDLE && start_ok) next_state = LOAD;
    else if (state == LOAD && last_rd) next_state = DRAIN;
    else if (state == DRAIN) next_state = DONE;
    else if (state == DONE) next_state = IDLE;
  end
  // outputs: combinational read enable so the FIFO is never read while empty
  always_comb begin
    o_store_valid = (state == LOAD) && !i_fifo_empty && (rd_cnt < n_full);
    o_busy = (state == LOAD) || (state == DRAIN);
    o_done = state == DONE;
    o_ram_we = rd_d;
    o_ram_addr = addr_q;
    o_ram_wdata = i_store_data;
    o_err = err_q;
  end
  // read counter, size latch, one-cycle write pipeline and error pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_reg <= '0;
      rd_cnt <= '0;
      addr_q <= '0;
      rd_d <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rd_d <= o_store_valid;
      err_q <= (state == IDLE) && i_start && !start_ok;
      if (state == IDLE && start_ok) begin
        n_reg <= i_log2n;
        rd_cnt <= '0;
      end
      if (o_store_valid) begin
        rd_cnt <= rd_cnt + 1'b1;
        addr_q <= rev_full >> (AW_N - n_reg);
      end
      if (state == DONE) rd_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: FIFO model plus behavioural scoreboard for fft_input_loader
module tb_fft_input_loader;
  logic clk = 0, rst = 1, start = 0, fifo_empty = 1;
  logic [3:0] log2n = 0;
  logic [31:0] store_data = 0, ram_wdata;
  logic store_valid, ram_we, busy, done, err;
  logic [9:0] ram_addr;
  int total = 0, bad = 0;
  logic [31:0] fq[$], expq[$], wlog_data[$], dval;
  int wlog_addr[$];
  bit gap_mode = 0;
  int fcyc = 0;
  bit active = 0, done_exp = 0, err_exp = 0, we_exp = 0, sv_prev = 0, last_flag = 0, prev_done = 0, done_seen = 0;
  int n_m = 3, widx = 0, reads = 0, addr_exp = 0, cyc = 0, last_sv_cyc = 0, done_cnt = 0, err_cnt = 0, sv_cnt = 0;
  int nid = 1;

  fft_input_loader dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_log2n(log2n), .i_fifo_empty(fifo_empty),
    .o_store_valid(store_valid), .i_store_data(store_data), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int bitrev(input int i, input int n);
    int r = 0;
    for (int k = 0; k < n; k++) if (((i >> k) & 1) != 0) r |= 1 << (n - 1 - k);
    return r;
  endfunction

  // FIFO with registered dout; every popped word is what the next RAM write must carry
  always @(posedge clk) begin
    if (store_valid && fq.size() > 0) begin
      dval = fq.pop_front();
      store_data <= dval;
      expq.push_back(dval);
    end
    if (rst) expq.delete();
    fcyc++;
    fifo_empty <= (fq.size() == 0) || (gap_mode && ((fcyc / 3) % 2 == 1));
  end

  // behavioural model: load of N writes in FIFO order at bitrev addresses, done one cycle after last write
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      active = 0; done_exp = 0; err_exp = 0; we_exp = 0; addr_exp = 0;
      widx = 0; reads = 0; last_flag = 0;
    end else begin
      we_exp = sv_prev;
      err_exp = 0;
      prev_done = done_exp;
      done_exp = last_flag;
      last_flag = 0;
      if (done_exp) active = 0;
      if (start && !active && !prev_done) begin
        if (log2n >= 3 && log2n <= 10) begin
          active = 1; n_m = int'(log2n); widx = 0; reads = 0;
        end else err_exp = 1;
      end
    end
    #1;
    chk("busy", busy, active);
    chk("done", done, done_exp);
    chk("err", err, err_exp);
    chk("ram_we", ram_we, we_exp);
    chk("store_valid", store_valid, active && reads < (1 << n_m) && !fifo_empty);
    if (ram_we) begin
      addr_exp = bitrev(widx, n_m);
      if (expq.size() == 0) chk("wdata_avail", 0, 1);
      else chk("wdata", ram_wdata, expq.pop_front());
      wlog_addr.push_back(int'(ram_addr));
      wlog_data.push_back(ram_wdata);
      widx++;
      if (widx == (1 << n_m)) last_flag = 1;
    end
    chk("ram_addr", ram_addr, addr_exp);
    if (store_valid) begin
      reads++; sv_cnt++; last_sv_cyc = cyc;
    end
    if (err) err_cnt++;
    if (done) begin
      done_seen = 1; done_cnt++;
      chk("done_latency", cyc - last_sv_cyc, 2);
    end
    sv_prev = store_valid;
  end

  task automatic pulse(input int n);
    @(negedge clk);
    start = 1; log2n = 4'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_load(input int n);
    wlog_addr.delete(); wlog_data.delete();
    done_seen = 0;
    pulse(n);
    for (int i = 0; i < 4000 && !done_seen; i++) @(negedge clk);
    chk("done_seen", done_seen, 1);
  endtask

  task automatic push_ids(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      fq.push_back({16'(nid), 16'($urandom)});
      nid++;
    end
  endtask

  initial begin
    int e0, s0, d0;
    int a4[4];
    int a8[8];
    a8 = '{0, 4, 2, 6, 1, 5, 3, 7};
    a4 = '{0, 8, 4, 12};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sv", store_valid, 0);
    // preloaded 8 samples, N=8
    for (int k = 0; k < 8; k++) fq.push_back({16'(k + 1), 16'h0});
    nid = 9;
    repeat (2) @(negedge clk);
    do_load(3);
    chk("t1_count", wlog_addr.size(), 8);
    for (int k = 0; k < 8 && k < wlog_addr.size(); k++) begin
      chk("t1_addr", wlog_addr[k], a8[k]);
      chk("t1_data", wlog_data[k], (k + 1) << 16);
    end
    // N=16 with FIFO empty toggling
    fq.delete(); nid = 1;
    gap_mode = 1;
    push_ids(16);
    do_load(4);
    gap_mode = 0;
    chk("t2_count", wlog_addr.size(), 16);
    if (wlog_addr.size() == 16) begin
      for (int k = 0; k < 4; k++) chk("t2_addr", wlog_addr[k], a4[k]);
      chk("t2_addr_last", wlog_addr[15], 15);
      for (int k = 0; k < 16; k++) chk("t2_order", int'(wlog_data[k][31:16]), k + 1);
    end
    // illegal sizes
    e0 = err_cnt; s0 = sv_cnt;
    pulse(2);
    repeat (3) @(negedge clk);
    pulse(11);
    repeat (3) @(negedge clk);
    chk("t3_err_pulses", err_cnt - e0, 2);
    chk("t3_no_reads", sv_cnt - s0, 0);
    // 12 samples, load 8, leave 4, then top up
    fq.delete(); nid = 1;
    push_ids(12);
    repeat (2) @(negedge clk);
    do_load(3);
    @(negedge clk);
    chk("t4_left", fq.size(), 4);
    if (wlog_data.size() == 8) chk("t4_first", int'(wlog_data[0][31:16]), 1);
    push_ids(4);
    do_load(3);
    if (wlog_data.size() == 8) begin
      chk("t4b_first", int'(wlog_data[0][31:16]), 9);
      chk("t4b_last", int'(wlog_data[7][31:16]), 16);
    end
    // ignored restart, then reset mid-load
    fq.delete();
    push_ids(16);
    wlog_addr.delete(); wlog_data.delete();
    pulse(4);
    pulse(5);
    for (int i = 0; i < 100 && wlog_addr.size() < 5; i++) @(negedge clk);
    chk("t5_five_writes", wlog_addr.size(), 5);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_busy", busy, 0);
    chk("t5_we", ram_we, 0);
    chk("t5_addr", ram_addr, 0);
    chk("t5_sv", store_valid, 0);
    do_load(3);
    chk("t5_count", wlog_addr.size(), 8);
    if (wlog_addr.size() > 1) begin
      chk("t5_addr0", wlog_addr[0], 0);
      chk("t5_addr1", wlog_addr[1], 4);
    end
    // N=1024 continuous
    fq.delete();
    repeat (2) @(negedge clk);
    push_ids(1024);
    d0 = done_cnt;
    do_load(10);
    repeat (2) @(negedge clk);
    chk("t6_count", wlog_addr.size(), 1024);
    if (wlog_addr.size() == 1024) begin
      chk("t6_addr1", wlog_addr[1], 512);
      chk("t6_addr1023", wlog_addr[1023], 1023);
    end
    chk("t6_done_pulses", done_cnt - d0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
